// File: rtl/serial_magnitude_comparator_if.sv
// Request/result handshake bundle for the serial magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             i_w_start_valid;
  logic             o_w_start_ready;
  logic [WIDTH-1:0] i_w_a;
  logic [WIDTH-1:0] i_w_b;
  logic             o_w_done;
  logic             i_w_done_ready;
  logic             o_w_lt;
  logic             o_w_gt;
  logic             o_w_eq;
  logic             o_w_busy;
  logic [CNT_W-1:0] o_w_bits;

  modport master (
    output i_w_start_valid, i_w_a, i_w_b, i_w_done_ready,
    input  o_w_start_ready, o_w_done, o_w_lt, o_w_gt,
    input  o_w_eq, o_w_busy, o_w_bits
  );

  modport slave (
    input  i_w_start_valid, i_w_a, i_w_b, i_w_done_ready,
    output o_w_start_ready, o_w_done, o_w_lt, o_w_gt,
    output o_w_eq, o_w_busy, o_w_bits
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial unsigned compare with early exit.
// One-bit comparator cell plus its sequencing controller.
module comparator (
  input  logic a_i,
  input  logic b_i,
  output logic lt_o,
  output logic gt_o,
  output logic eq_o
);
  assign lt_o = ~a_i & b_i;
  assign gt_o = a_i & ~b_i;
  assign eq_o = ~(a_i ^ b_i);
endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic i_w_clk,
  input logic i_w_rst_n,
  serial_magnitude_comparator_if.slave cmp
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic c_lt, c_gt, c_eq;

  comparator u_cell (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .lt_o (c_lt),
    .gt_o (c_gt),
    .eq_o (c_eq)
  );

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    bits_d  = bits_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmp.i_w_start_valid) begin
          a_d     = cmp.i_w_a;
          b_d     = cmp.i_w_b;
          idx_d   = IDX_W'(WIDTH - 1);
          bits_d  = '0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bits_d = bits_q + CNT_W'(1);
        unique case (1'b1)
          c_lt: begin
            lt_d    = 1'b1;
            state_d = S_DONE;
          end
          c_gt: begin
            gt_d    = 1'b1;
            state_d = S_DONE;
          end
          c_eq: begin
            if (idx_q == '0) begin
              eq_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q - IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        if (cmp.i_w_done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode state only; no input-to-output path.
  assign cmp.o_w_start_ready = (state_q == S_IDLE);
  assign cmp.o_w_busy        = (state_q == S_RUN);
  assign cmp.o_w_done        = (state_q == S_DONE);
  assign cmp.o_w_lt          = lt_q;
  assign cmp.o_w_gt          = gt_q;
  assign cmp.o_w_eq          = eq_q;
  assign cmp.o_w_bits        = bits_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed vector bench for serial_magnitude_comparator.
// Vectors with hand-computed flags/bit counts plus corner sequences.
module tb_serial_magnitude_comparator;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst_n;
  int checks;
  int errors;

  serial_magnitude_comparator_if #(.WIDTH(W), .CNT_W(CW)) cmp ();

  serial_magnitude_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .cmp       (cmp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         lt;
    logic         gt;
    logic         eq;
    int           bits;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " ready"}, int'(cmp.o_w_start_ready), 1);
    chk({name, " done"}, int'(cmp.o_w_done), 0);
    chk({name, " busy"}, int'(cmp.o_w_busy), 0);
    chk({name, " flags"},
        int'({cmp.o_w_lt, cmp.o_w_gt, cmp.o_w_eq}), 0);
    chk({name, " bits"}, int'(cmp.o_w_bits), 0);
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!cmp.o_w_start_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("start ready timeout", 0, 1);
    cmp.i_w_start_valid = 1'b1;
    cmp.i_w_a = a;
    cmp.i_w_b = b;
    @(posedge clk); #1;
    cmp.i_w_start_valid = 1'b0;
    cmp.i_w_a = W'($urandom);
    cmp.i_w_b = W'($urandom);
  endtask

  // Counts cycles from the accepting edge until done, checking RUN shape.
  task automatic wait_done(output int lat);
    int bad;
    bad = 0;
    lat = 0;
    while (!cmp.o_w_done && lat < 40) begin
      if (!cmp.o_w_busy || cmp.o_w_start_ready ||
          cmp.o_w_lt || cmp.o_w_gt || cmp.o_w_eq) bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (!cmp.o_w_done) chk("done timeout", 0, 1);
    chk("run shape violations", bad, 0);
  endtask

  task automatic check_result(input string name, input vec_t v, input int lat);
    chk({name, " latency"}, lat, v.bits);
    chk({name, " lt"}, int'(cmp.o_w_lt), int'(v.lt));
    chk({name, " gt"}, int'(cmp.o_w_gt), int'(v.gt));
    chk({name, " eq"}, int'(cmp.o_w_eq), int'(v.eq));
    chk({name, " bits"}, int'(cmp.o_w_bits), v.bits);
  endtask

  task automatic handshake(input string name, input vec_t v);
    cmp.i_w_done_ready = 1'b1;
    @(posedge clk); #1;
    cmp.i_w_done_ready = 1'b0;
    chk({name, " idle ready"}, int'(cmp.o_w_start_ready), 1);
    chk({name, " idle done"}, int'(cmp.o_w_done), 0);
    chk({name, " idle bits"}, int'(cmp.o_w_bits), v.bits);
    chk({name, " idle flags"}, int'({cmp.o_w_lt, cmp.o_w_gt, cmp.o_w_eq}),
        int'({v.lt, v.gt, v.eq}));
  endtask

  initial begin
    int lat;
    int dones;
    vec_t v;
    checks = 0;
    errors = 0;

    vecs[0]  = '{8'hA5, 8'h25, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8};
    vecs[2]  = '{8'h80, 8'h40, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{8'h03, 8'h07, 1'b1, 1'b0, 1'b0, 6};
    vecs[4]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8};
    vecs[6]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{8'hC3, 8'hC7, 1'b1, 1'b0, 1'b0, 6};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8};
    vecs[9]  = '{8'hF0, 8'hE0, 1'b0, 1'b1, 1'b0, 4};
    vecs[10] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8};

    cmp.i_w_start_valid = 1'b0;
    cmp.i_w_done_ready = 1'b0;
    cmp.i_w_a = '0;
    cmp.i_w_b = '0;
    rst_n = 1'b0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      start(vecs[i].a, vecs[i].b);
      wait_done(lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      handshake($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure on an equal-operand result.
    v = vecs[10];
    start(v.a, v.b);
    wait_done(lat);
    check_result("bp", v, lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d done", k), int'(cmp.o_w_done), 1);
      chk($sformatf("bp hold%0d flags", k),
          int'({cmp.o_w_lt, cmp.o_w_gt, cmp.o_w_eq}), 1);
      chk($sformatf("bp hold%0d bits", k), int'(cmp.o_w_bits), 8);
    end
    handshake("bp", v);

    // Start request while busy must be ignored.
    v = vecs[2];
    start(v.a, v.b);
    cmp.i_w_start_valid = 1'b1;
    cmp.i_w_a = 8'h00;
    cmp.i_w_b = 8'hFF;
    chk("busy ready low", int'(cmp.o_w_start_ready), 0);
    chk("busy busy high", int'(cmp.o_w_busy), 1);
    @(posedge clk); #1;
    chk("busy done", int'(cmp.o_w_done), 1);
    chk("busy ready in done", int'(cmp.o_w_start_ready), 0);
    check_result("busy", v, 1);
    cmp.i_w_start_valid = 1'b0;
    handshake("busy", v);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (cmp.o_w_done || !cmp.o_w_start_ready) dones++;
    end
    chk("busy extra activity", dones, 0);

    // Reset mid-run discards the compare.
    start(8'h01, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrun reset");
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (cmp.o_w_done || cmp.o_w_busy) dones++;
    end
    chk("midrun reset activity", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset ready", int'(cmp.o_w_start_ready), 1);
    v = vecs[3];
    start(v.a, v.b);
    wait_done(lat);
    check_result("post reset", v, lat);
    handshake("post reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle N-bit magnitude comparator controller. It sequences a single instance of the team's one-bit `comparator` cell over two captured operands, one bit per cycle, MSB first. It stops early at the first differing bit. Results are returned through a valid/ready handshake, so the block can sit between a register-file read port and a branch or flag unit in the lab datapath.

## Interface
- `WIDTH`, default 8: operand width in bits, at least 1.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the bit-count output.

- `i_w_clk` input 1: single clock, rising edge.
- `i_w_rst_n` input 1: reset, asynchronous and active-low.
- `i_w_start_valid` input 1: request to compare `i_w_a` and `i_w_b`.
- `o_w_start_ready` output 1: block can accept a request (high only in IDLE).
- `i_w_a` input WIDTH: operand A, sampled on the accepting edge only.
- `i_w_b` input WIDTH: operand B, sampled on the accepting edge only.
- `o_w_done` output 1: result valid.
- `i_w_done_ready` input 1: consumer accepts the result.
- `o_w_lt` output 1: A < B, unsigned.
- `o_w_gt` output 1: A > B, unsigned.
- `o_w_eq` output 1: A == B.
- `o_w_busy` output 1: state is RUN.
- `o_w_bits` output CNT_W: number of bit positions examined for the current result.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **Accept:** a request is accepted on a rising edge with `i_w_start_valid & o_w_start_ready`.
  - Operands are captured into internal registers.
  - The bit index is set to WIDTH-1 and the bit counter to 0.
  - `o_w_lt`, `o_w_gt` and `o_w_eq` are cleared.
  - The state moves to RUN.
- **RUN:** the comparator cell is fed the captured A and B bits at the current index. On each edge the bit counter increments.
  - Cell reports lt or gt: latch that flag, go to DONE.
  - Cell reports eq and index == 0: latch `o_w_eq`, go to DONE.
  - Cell reports eq and index > 0: decrement index, stay in RUN.
- **DONE:** `o_w_done` = 1. Result flags and `o_w_bits` are held stable. When `i_w_done_ready` = 1 on an edge, go to IDLE.
- **IDLE:** result flags and `o_w_bits` keep their last values until the next accept. `o_w_done` = 0.
- **Flag invariant:** exactly one of lt/gt/eq is high whenever `o_w_done` = 1. All three are 0 while in RUN.
- **Requests while busy:** `i_w_start_valid` in RUN or DONE is ignored (ready low). Operand changes during RUN do not affect the result.
- **Reset values (async assert, any state):**
  - state IDLE
  - `o_w_start_ready` = 1
  - `o_w_done` = 0
  - `o_w_busy` = 0
  - lt/gt/eq = 0
  - `o_w_bits` = 0
  - internal operands and index = 0
- **Reset mid-operation:** an in-flight compare is discarded, with no `o_w_done` pulse. After deassertion the block is ready in the next cycle.

## Timing
- **Output timing:** all outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- **Early exit:** let j be the highest bit index where A and B differ.
  - `o_w_done` rises WIDTH-j cycles after the accepting edge.
  - `o_w_bits` = WIDTH-j.
- **Equal operands:** `o_w_done` rises WIDTH cycles after accept, with `o_w_bits` = WIDTH.
- **Latency range:** minimum 1 cycle (MSB differs), maximum WIDTH cycles.
- **WIDTH = 1:** always exactly one RUN cycle.
- **Throughput:** after the done handshake the block spends at least one cycle in IDLE before the next accept. Back-to-back period is latency + 2 cycles with `i_w_done_ready` held high.
- **Backpressure:** `o_w_done` and the flags stay asserted and unchanged for any number of cycles while `i_w_done_ready` = 0.

## Test plan
- **Reset:** assert `i_w_rst_n` = 0 asynchronously between edges.
  - Outputs immediately: ready = 1, done/busy/lt/gt/eq = 0, bits = 0.
- **MSB differs (WIDTH = 8):** A = 0xA5, B = 0x25, done_ready = 1.
  - `o_w_done` one cycle after accept with gt = 1, bits = 1.
  - Back in IDLE the following cycle.
- **LSB differs:** A = 0x12, B = 0x13.
  - busy for 8 cycles, then done with lt = 1, bits = 8.
- **Equal operands with backpressure:** A = B = 0x5A, `i_w_done_ready` held 0 for 3 cycles after done.
  - Done on cycle 8 with eq = 1, bits = 8.
  - Flags and done held stable for those 3 cycles; IDLE one cycle after ready rises.
- **Busy behaviour:** accept A = 0x80, B = 0x40.
  - During RUN, pulse start_valid with A = 0x00, B = 0xFF. The pulse is ignored and ready stays 0.
  - Result is gt = 1, bits = 1.
  - Only one done handshake occurs.
- **Reset mid-run:** accept A = 0x01, B = 0x00, assert reset after 3 RUN cycles.
  - No done pulse, all outputs at reset values.
  - After release, a fresh compare A = 0x03, B = 0x07 yields lt = 1, bits = 6.
